// File: rtl/ram_arb_pkg.sv
// Shared types and address map for the RAM/IO port arbiter.
// Holds FSM state encoding, region codes and the default address constants.
package ram_arb_pkg;

    localparam int RAM_DEPTH   = 64;
    localparam int IO_OUT_ADDR = 64;
    localparam int IO_IN_ADDR  = 65;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        REG_RAM     = 2'd0,
        REG_IO_OUT  = 2'd1,
        REG_IO_IN   = 2'd2,
        REG_ILLEGAL = 2'd3
    } region_t;

endpackage

// File: rtl/ram_addr_decode.sv
// Combinational address decoder for the arbiter.
// Maps an address onto RAM, the IO64 latch, the IO65 input, or illegal.
module ram_addr_decode #(
    parameter int ADDR_W      = 8,
    parameter int RAM_DEPTH   = ram_arb_pkg::RAM_DEPTH,
    parameter int IO_OUT_ADDR = ram_arb_pkg::IO_OUT_ADDR,
    parameter int IO_IN_ADDR  = ram_arb_pkg::IO_IN_ADDR
) (
    input  logic [ADDR_W-1:0] ADDR,
    output logic [1:0]        REGION
);
    import ram_arb_pkg::*;

    localparam logic [ADDR_W-1:0] RAM_LAST = ADDR_W'(RAM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] OUT_A    = ADDR_W'(IO_OUT_ADDR);
    localparam logic [ADDR_W-1:0] IN_A     = ADDR_W'(IO_IN_ADDR);

    // Classify the address; the RAM window takes precedence over IO
    always_comb begin
        REGION = REG_ILLEGAL;
        if (ADDR <= RAM_LAST) begin
            REGION = REG_RAM;
        end else if (ADDR == OUT_A) begin
            REGION = REG_IO_OUT;
        end else if (ADDR == IN_A) begin
            REGION = REG_IO_IN;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter for the data RAM and IO64/IO65 ports.
// IDLE -> ACCESS -> RESP handshake with registered GNT/ACK and RAM controls.
module ram_port_arbiter #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int RAM_DEPTH   = ram_arb_pkg::RAM_DEPTH,
    parameter int IO_OUT_ADDR = ram_arb_pkg::IO_OUT_ADDR,
    parameter int IO_IN_ADDR  = ram_arb_pkg::IO_IN_ADDR
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              A_REQ,
    input  logic              A_WEN,
    input  logic [ADDR_W-1:0] A_ADDR,
    input  logic [DATA_W-1:0] A_WDATA,
    output logic              A_GNT,
    output logic              A_ACK,
    output logic [DATA_W-1:0] A_RDATA,
    input  logic              B_REQ,
    input  logic              B_WEN,
    input  logic [ADDR_W-1:0] B_ADDR,
    input  logic [DATA_W-1:0] B_WDATA,
    output logic              B_GNT,
    output logic              B_ACK,
    output logic [DATA_W-1:0] B_RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic              MEM_WEN,
    input  logic [DATA_W-1:0] MEM_RDATA,
    input  logic [DATA_W-1:0] IO65_IN,
    output logic [DATA_W-1:0] IO64_OUT,
    output logic              ADDR_ERR
);
    import ram_arb_pkg::*;

    arb_state_t        state;
    region_t           region_q;
    logic              ptr_b;
    logic              win_b;
    logic              wen_q;
    logic [DATA_W-1:0] hold_q;

    logic              pick_b;
    logic              req_wen;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic [1:0]        req_region;
    logic [DATA_W-1:0] rsp_data;

    // Pick the winner: pointer breaks ties, a lone request always wins
    always_comb begin
        pick_b    = B_REQ && (!A_REQ || ptr_b);
        req_wen   = pick_b ? B_WEN   : A_WEN;
        req_addr  = pick_b ? B_ADDR  : A_ADDR;
        req_wdata = pick_b ? B_WDATA : A_WDATA;
    end

    ram_addr_decode #(
        .ADDR_W      (ADDR_W),
        .RAM_DEPTH   (RAM_DEPTH),
        .IO_OUT_ADDR (IO_OUT_ADDR),
        .IO_IN_ADDR  (IO_IN_ADDR)
    ) u_decode (
        .ADDR   (req_addr),
        .REGION (req_region)
    );

    // Transaction FSM with registered handshake and RAM/IO side effects
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            region_q  <= REG_RAM;
            ptr_b     <= 1'b0;
            win_b     <= 1'b0;
            wen_q     <= 1'b0;
            hold_q    <= '0;
            A_GNT     <= 1'b0;
            B_GNT     <= 1'b0;
            A_ACK     <= 1'b0;
            B_ACK     <= 1'b0;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_WEN   <= 1'b0;
            IO64_OUT  <= '0;
            ADDR_ERR  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (A_REQ || B_REQ) begin
                        win_b     <= pick_b;
                        ptr_b     <= !pick_b;
                        wen_q     <= req_wen;
                        region_q  <= region_t'(req_region);
                        MEM_ADDR  <= req_addr;
                        MEM_WDATA <= req_wdata;
                        MEM_WEN   <= req_wen &&
                                     (region_t'(req_region) == REG_RAM);
                        A_GNT     <= !pick_b;
                        B_GNT     <= pick_b;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    MEM_WEN  <= 1'b0;
                    A_GNT    <= 1'b0;
                    B_GNT    <= 1'b0;
                    A_ACK    <= !win_b;
                    B_ACK    <= win_b;
                    ADDR_ERR <= (region_q == REG_ILLEGAL);
                    if (wen_q && region_q == REG_IO_OUT) begin
                        IO64_OUT <= MEM_WDATA;
                    end
                    if (!wen_q && region_q == REG_IO_IN) begin
                        hold_q <= IO65_IN;
                    end
                    if (!wen_q && region_q == REG_IO_OUT) begin
                        hold_q <= IO64_OUT;
                    end
                    state <= RESP;
                end
                RESP: begin
                    A_ACK    <= 1'b0;
                    B_ACK    <= 1'b0;
                    ADDR_ERR <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Response data source: RAM output, IO hold register, or zero
    always_comb begin
        rsp_data = '0;
        if (!wen_q) begin
            case (region_q)
                REG_RAM:    rsp_data = MEM_RDATA;
                REG_IO_OUT: rsp_data = hold_q;
                REG_IO_IN:  rsp_data = hold_q;
                default:    rsp_data = '0;
            endcase
        end
    end

    assign A_RDATA = A_ACK ? rsp_data : '0;
    assign B_RDATA = B_ACK ? rsp_data : '0;

endmodule
